alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-state instruction sequencer driving an external registered 4-bit ALU
//
// Purpose:
//   Accepts 12-bit instructions over a valid/ready handshake. A load-immediate
//   instruction writes the 4-bit immediate to R[rd] on the accepting edge and
//   retires at once. An ALU instruction latches the opcode and both operands.
//   It presents them to the external ALU for ISSUE and CAPTURE. It then writes
//   the registered ALU result back to R[rd] on the edge that ends CAPTURE.
//
// Instruction word:
//   [11]    kind   (0 = ALU op, 1 = load immediate)
//   [10:8]  opcode
//   [7:6]   rd
//   [5:4]   rs1
//   [3:2]   rs2
//   [3:0]   imm    (load immediate only)
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   instruction offered
//   instr_ready  out  sequencer can accept (IDLE and out of reset)
//   instr        in   12-bit instruction word
//   alu_opcode   out  opcode to the ALU
//   alu_in_1     out  first ALU operand
//   alu_in_2     out  second ALU operand
//   alu_result   in   ALU output, registered by the ALU one edge after operands
//   res_valid    out  one-cycle pulse per ALU write-back
//   res_data     out  last written-back value
//   res_rd       out  destination of last write-back
//   zero_flag    out  last written-back value was zero
//   retired      out  completed-instruction counter, wraps
//   dbg_sel      in   register select for debug read
//   dbg_data     out  combinational read of R[dbg_sel]

module alu_sequencer #(
  parameter int RET_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [11:0]          instr,
  output logic [2:0]           alu_opcode,
  output logic [3:0]           alu_in_1,
  output logic [3:0]           alu_in_2,
  input  logic [3:0]           alu_result,
  output logic                 res_valid,
  output logic [3:0]           res_data,
  output logic [1:0]           res_rd,
  output logic                 zero_flag,
  output logic [RET_CNT_W-1:0] retired,
  input  logic [1:0]           dbg_sel,
  output logic [3:0]           dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_regs [0:3];
  logic [1:0]  r_rd;

  // Instruction field decode; only meaningful on an accepting edge.
  logic        w_kind_li;
  logic [2:0]  w_opcode;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs1;
  logic [1:0]  w_rs2;
  logic [3:0]  w_imm;

  logic        w_idle;
  logic        w_wb;
  logic        w_accept;
  logic        w_accept_li;
  logic        w_accept_alu;

  assign w_kind_li = instr[11];
  assign w_opcode  = instr[10:8];
  assign w_rd      = instr[7:6];
  assign w_rs1     = instr[5:4];
  assign w_rs2     = instr[3:2];
  assign w_imm     = instr[3:0];

  assign w_accept     = instr_valid & instr_ready;
  assign w_accept_li  = w_accept & w_kind_li;
  assign w_accept_alu = w_accept & ~w_kind_li;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Load immediates complete on the accepting edge, so only ALU ops leave IDLE.
        if (w_accept_alu) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_idle      = 1'b0;
    w_wb        = 1'b0;
    instr_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
      end
      S_CAPTURE: begin
        // alu_result already holds the registered result of the ISSUE-cycle operands.
        w_wb = 1'b1;
      end
      default: begin
        w_idle = 1'b0;
      end
    endcase
    // Ready is also gated by rst_n so it stays low while reset is held.
    instr_ready = w_idle & rst_n;
  end

  // ---------------------------------------------------------------------------
  // Register file. A load immediate (IDLE) and a write-back (CAPTURE) can never
  // coincide, so a single write port is enough.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 4'h0;
      end
    end else if (w_accept_li) begin
      r_regs[w_rd] <= w_imm;
    end else if (w_wb) begin
      r_regs[r_rd] <= alu_result;
    end
  end

  assign dbg_data = r_regs[dbg_sel];

  // ---------------------------------------------------------------------------
  // Operand latch. The ALU-facing registers load only on an ALU accept, so they
  // hold through ISSUE and CAPTURE and keep their last value while in IDLE.
  // Operands are read here, before any write-back, which handles aliasing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 3'd0;
      alu_in_1   <= 4'h0;
      alu_in_2   <= 4'h0;
      r_rd       <= 2'd0;
    end else if (w_accept_alu) begin
      alu_opcode <= w_opcode;
      alu_in_1   <= r_regs[w_rs1];
      alu_in_2   <= r_regs[w_rs2];
      r_rd       <= w_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back reporting. The res_valid pulse lands in the first IDLE cycle after
  // CAPTURE. res_data and res_rd hold until the next write-back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= 4'h0;
      res_rd    <= 2'd0;
      zero_flag <= 1'b0;
    end else begin
      res_valid <= w_wb;
      if (w_wb) begin
        res_data  <= alu_result;
        res_rd    <= r_rd;
        zero_flag <= (alu_result == 4'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retired counter, free-running wrap
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (w_accept_li || w_wb) begin
      retired <= retired + RET_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer

module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_in_1;
  logic [3:0]  alu_in_2;
  logic [3:0]  alu_result;
  logic        res_valid;
  logic [3:0]  res_data;
  logic [1:0]  res_rd;
  logic        zero_flag;
  logic [7:0]  retired;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;

  int errors;
  int checks;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_SHIFT = 3'b111;

  alu_sequencer #(.RET_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_in_1    (alu_in_1),
    .alu_in_2    (alu_in_2),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .zero_flag   (zero_flag),
    .retired     (retired),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 4-bit ALU model. Opcode 111 is a fixed left shift by two.
  initial alu_result = 4'h0;
  always @(posedge clk) begin
    case (alu_opcode)
      3'b000:  alu_result <= alu_in_1;
      3'b001:  alu_result <= alu_in_1 + alu_in_2;
      3'b010:  alu_result <= alu_in_1 - alu_in_2;
      3'b011:  alu_result <= alu_in_1 & alu_in_2;
      3'b100:  alu_result <= alu_in_1 | alu_in_2;
      3'b101:  alu_result <= ~alu_in_1;
      3'b110:  alu_result <= alu_in_1 ^ alu_in_2;
      default: alu_result <= {alu_in_1[1:0], 2'b00};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, {28'd0, dbg_data}, {28'd0, exp});
  endtask

  task automatic li(input logic [1:0] rd, input logic [3:0] imm);
    instr_valid = 1'b1;
    instr       = {1'b1, 3'b000, rd, 2'b00, imm};
    tick();
    instr_valid = 1'b0;
  endtask

  // Issue one ALU op and follow it to its write-back cycle (no trailing cycle,
  // so a following call is issued back-to-back).
  task automatic alu_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp);
    chk({tag, "_rdy_idle"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = {1'b0, op, rd, rs1, rs2, 2'b00};
    tick();
    instr_valid = 1'b0;
    instr       = 12'hFFF;
    chk({tag, "_rdy_issue"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, "_opc"}, {29'd0, alu_opcode}, {29'd0, op});
    chk({tag, "_in1"}, {28'd0, alu_in_1}, {28'd0, a});
    chk({tag, "_in2"}, {28'd0, alu_in_2}, {28'd0, b});
    tick();
    chk({tag, "_rdy_cap"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, "_vld_cap"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_in1_cap"}, {28'd0, alu_in_1}, {28'd0, a});
    tick();
    chk({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_data"}, {28'd0, res_data}, {28'd0, exp});
    chk({tag, "_rd"}, {30'd0, res_rd}, {30'd0, rd});
    chk({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, (exp == 4'h0)});
    chk({tag, "_rdy_back"}, {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 12'h000;
    dbg_sel     = 2'd0;

    // Reset state, before any clock edge and after one
    #2;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_retired", {24'd0, retired}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_opcode", {29'd0, alu_opcode}, 32'd0);
    chk("rst_in1", {28'd0, alu_in_1}, 32'd0);
    chk("rst_res_data", {28'd0, res_data}, 32'd0);
    chk("rst_zero", {31'd0, zero_flag}, 32'd0);
    dbg_chk("rst_r0", 2'd0, 4'h0);
    tick();
    chk("rst_ready_clk", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, instr_ready}, 32'd1);
    tick();

    // R1=5, R2=3, ADD rd3 -> 8
    li(2'd1, 4'h5);
    li(2'd2, 4'h3);
    chk("li_retired", {24'd0, retired}, 32'd2);
    chk("li_no_valid", {31'd0, res_valid}, 32'd0);
    alu_op("add", OP_ADD, 2'd3, 2'd1, 2'd2, 4'h5, 4'h3, 4'h8);
    chk("add_retired", {24'd0, retired}, 32'd3);
    dbg_chk("add_r3", 2'd3, 4'h8);
    tick();
    chk("pulse_end", {31'd0, res_valid}, 32'd0);
    chk("data_hold", {28'd0, res_data}, 32'd8);

    // SUB wraps to E, XOR with aliased sources gives zero
    li(2'd1, 4'h3);
    li(2'd2, 4'h5);
    alu_op("sub", OP_SUB, 2'd0, 2'd1, 2'd2, 4'h3, 4'h5, 4'hE);
    dbg_chk("sub_r0", 2'd0, 4'hE);
    tick();
    alu_op("xor", OP_XOR, 2'd2, 2'd1, 2'd1, 4'h3, 4'h3, 4'h0);
    chk("xor_retired", {24'd0, retired}, 32'd7);
    tick();
    li(2'd3, 4'h9);
    chk("li_keeps_zero", {31'd0, zero_flag}, 32'd1);
    chk("li_keeps_rd", {30'd0, res_rd}, 32'd2);
    chk("li_retired2", {24'd0, retired}, 32'd8);

    // Shift then back-to-back ADD reading the written-back R1
    li(2'd1, 4'h7);
    alu_op("shift", OP_SHIFT, 2'd1, 2'd1, 2'd0, 4'h7, 4'hE, 4'hC);
    alu_op("b2b", OP_ADD, 2'd2, 2'd1, 2'd1, 4'hC, 4'hC, 4'h8);
    chk("b2b_retired", {24'd0, retired}, 32'd11);
    dbg_chk("b2b_r1", 2'd1, 4'hC);
    tick();

    // instr_valid held high: one accept per three cycles, junk ignored while busy
    li(2'd0, 4'h1);
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      instr = (cyc % 3 == 0) ? {1'b0, OP_ADD, 2'd0, 2'd0, 2'd0, 2'b00} : 12'h80F;
      chk("held_ready", {31'd0, instr_ready}, {31'd0, (cyc % 3 == 0)});
      chk("held_valid", {31'd0, res_valid}, {31'd0, (cyc % 3 == 0) && (cyc != 0)});
      tick();
    end
    instr_valid = 1'b0;
    chk("held_last_valid", {31'd0, res_valid}, 32'd1);
    chk("held_data", {28'd0, res_data}, 32'd8);
    chk("held_retired", {24'd0, retired}, 32'd15);
    dbg_chk("held_r0", 2'd0, 4'h8);
    tick();

    // Reset asserted mid-CAPTURE aborts the op
    li(2'd1, 4'h5);
    li(2'd2, 4'h3);
    instr_valid = 1'b1;
    instr       = {1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 2'b00};
    tick();
    instr_valid = 1'b0;
    tick();
    chk("abort_in_cap", {31'd0, instr_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_retired", {24'd0, retired}, 32'd0);
    chk("abort_ready", {31'd0, instr_ready}, 32'd0);
    chk("abort_in1", {28'd0, alu_in_1}, 32'd0);
    dbg_chk("abort_r1", 2'd1, 4'h0);
    dbg_chk("abort_r3", 2'd3, 4'h0);
    tick();
    chk("abort_valid_clk", {31'd0, res_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("abort_no_wb", {31'd0, res_valid}, 32'd0);
    chk("abort_ret_after", {24'd0, retired}, 32'd0);
    li(2'd1, 4'h6);
    alu_op("post_rst", OP_ADD, 2'd2, 2'd1, 2'd1, 4'h6, 4'h6, 4'hC);
    chk("post_rst_retired", {24'd0, retired}, 32'd2);
    tick();

    // Retired counter wrap after 256 load immediates
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) begin
      li(2'(i % 4), 4'(i));
    end
    chk("wrap_255", {24'd0, retired}, 32'd255);
    li(2'd0, 4'h0);
    chk("wrap_0", {24'd0, retired}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
